// File: rtl/score4_pkg.sv
// Shared types and constants for the Score 4 datapath: panel geometry,
// cell codes, panel-update FSM states and column-select helpers.
package score4_pkg;

    localparam int COLS = 7;
    localparam int ROWS = 6;
    localparam logic [5:0] MAX_MOVES = 6'd42;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        P1    = 2'b01,
        P2    = 2'b10
    } cell_t;

    // [col][row], row ROWS-1 is the bottom of the board
    typedef logic [COLS-1:0][ROWS-1:0][1:0] panel_t;

    typedef enum logic [1:0] {
        IDLE,
        DROP,
        FULL
    } state_t;

    function automatic logic is_onehot(input logic [COLS-1:0] v);
        return (v != '0) && ((v & (v - COLS'(1))) == '0);
    endfunction

    function automatic logic [2:0] onehot_index(input logic [COLS-1:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < COLS; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/panel_update_if.sv
// Move-request and panel/status bundle between the move source,
// free_row, the display logic and panel_update.
interface panel_update_if;

    logic                  new_game;
    logic [6:0]            play;
    logic                  play_req;
    logic [2:0]            free;
    logic                  valid;
    score4_pkg::panel_t    panel;
    logic [1:0]            turn;
    logic                  busy;
    logic                  move_done;
    logic                  invalid_move;
    logic [5:0]            move_count;
    logic                  draw;

    modport master (
        output new_game, play, play_req, free, valid,
        input  panel, turn, busy, move_done, invalid_move, move_count, draw
    );

    modport slave (
        input  new_game, play, play_req, free, valid,
        output panel, turn, busy, move_done, invalid_move, move_count, draw
    );

endinterface

// File: rtl/panel_update_drop_tick_gen.sv
// Fall-rate divider: counts while enabled and emits a one-cycle step
// every TICKS cycles; held at zero when disabled or cleared.
module drop_tick_gen #(
    parameter int TICKS = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic step_o
);

    localparam int W = (TICKS > 1) ? $clog2(TICKS) : 1;

    logic [W-1:0] tick_q;
    logic [W-1:0] tick_d;

    assign step_o = enable_i && (tick_q == W'(TICKS - 1));

    always_comb begin
        tick_d = tick_q + W'(1);
        if (clear_i || !enable_i || step_o) tick_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) tick_q <= '0;
        else        tick_q <= tick_d;
    end

endmodule

// File: rtl/panel_update.sv
// Score 4 panel owner: validates a column request, animates the falling
// piece one row per DROP_TICKS cycles, then commits it and swaps players.
module panel_update
    import score4_pkg::*;
#(
    parameter int         DROP_TICKS   = 4,
    parameter logic [1:0] FIRST_PLAYER = 2'b01
) (
    input  logic           clk,
    input  logic           rst_n,
    panel_update_if.slave  bus
);

    state_t     state_q;
    panel_t     panel_q;
    cell_t      turn_q;
    logic [2:0] col_q;
    logic [2:0] target_q;
    logic [2:0] pos_q;
    logic [5:0] move_count_q;
    logic       move_done_q;
    logic       invalid_move_q;
    logic       step;

    drop_tick_gen #(.TICKS(DROP_TICKS)) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (bus.new_game),
        .enable_i (state_q == DROP),
        .step_o   (step)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || bus.new_game) begin
            state_q        <= IDLE;
            panel_q        <= '0;
            turn_q         <= cell_t'(FIRST_PLAYER);
            col_q          <= '0;
            target_q       <= '0;
            pos_q          <= '0;
            move_count_q   <= '0;
            move_done_q    <= 1'b0;
            invalid_move_q <= 1'b0;
        end else begin
            move_done_q    <= 1'b0;
            invalid_move_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // free/valid are trusted only on this edge; the overlay
                    // would corrupt free_row's view once the drop starts
                    if (bus.play_req) begin
                        if (is_onehot(bus.play) && bus.valid) begin
                            col_q    <= onehot_index(bus.play);
                            target_q <= bus.free;
                            pos_q    <= '0;
                            state_q  <= DROP;
                        end else begin
                            invalid_move_q <= 1'b1;
                        end
                    end
                end
                DROP: begin
                    if (step) begin
                        if (pos_q == target_q) begin
                            panel_q[col_q][target_q] <= turn_q;
                            turn_q       <= (turn_q == P1) ? P2 : P1;
                            move_count_q <= move_count_q + 6'd1;
                            move_done_q  <= 1'b1;
                            state_q      <= (move_count_q + 6'd1 == MAX_MOVES) ? FULL : IDLE;
                        end else begin
                            pos_q <= pos_q + 3'd1;
                        end
                    end
                end
                FULL: begin
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Falling piece is shown on top of the stored panel while dropping
    always_comb begin
        bus.panel = panel_q;
        if (state_q == DROP) bus.panel[col_q][pos_q] = turn_q;
    end

    assign bus.turn         = turn_q;
    assign bus.busy         = (state_q == DROP);
    assign bus.draw         = (state_q == FULL);
    assign bus.move_done    = move_done_q;
    assign bus.invalid_move = invalid_move_q;
    assign bus.move_count   = move_count_q;

endmodule

// File: doc/panel_update.md
Name: panel_update

Overview:
Downstream stage of free_row in the Score 4 datapath. Holds the registered 7x6 game panel and consumes free_row's {free, valid} for the requested column. Validates and accepts a move, then animates the piece falling one row per DROP_TICKS cycles. Finally commits the piece, swaps the player and tracks the move count and draw condition. Its panel output feeds free_row and the display logic.

Parameters:
DROP_TICKS, 4, clock cycles per one-row fall step (must be >= 1)
FIRST_PLAYER, 2'b01, cell code of the player who moves first after reset or new_game

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous, active-low reset
new_game  in  1  synchronous clear of game state; priority below rst_n, above everything else
play  in  7  column select, one-hot, bit i = column i; sampled only with play_req
play_req  in  1  single-cycle move request
free  in  3  from free_row: highest empty row index of the selected column
valid  in  1  from free_row: selected column has an empty cell
panel  out  7x6x2  stored panel with falling-piece overlay; [col][row], row 5 = bottom
turn  out  2  cell code of the player to move (01 or 10)
busy  out  1  high while in DROP
move_done  out  1  one-cycle pulse on commit
invalid_move  out  1  one-cycle pulse on rejected request
move_count  out  6  committed moves, 0..42
draw  out  1  high while in FULL

Behaviour:
- Cell codes: 00 empty, 01 player 1, 10 player 2. Code 11 is never written.
- Reset values (rst_n=0 at an edge), also applied by new_game:
  - panel all 00
  - turn=FIRST_PLAYER
  - busy=0, move_done=0, invalid_move=0, draw=0
  - move_count=0
  - state=IDLE
  - internal tick and pos counters = 0
- new_game aborts any drop in progress. The falling piece is discarded, with no commit and no pulse.
- States are IDLE, DROP and FULL.
- IDLE, when play_req=1 at an edge:
  - Accept if play is one-hot (checked here, independent of free_row) and valid=1.
  - On accept: latch col=index(play) and target=free; set pos=0, tick=0; go to DROP.
  - On reject (zero or multi-hot play, or valid=0): pulse invalid_move in the following cycle. Panel, turn and move_count are unchanged; stay in IDLE.
- free and valid are sampled only on the acceptance edge. They are ignored during DROP because the overlay changes free_row's view of the panel.
- DROP:
  - busy=1.
  - panel output = stored panel, with cell [col][pos] forced to turn.
  - tick increments every cycle. When tick==DROP_TICKS-1, tick wraps to 0 and a step occurs.
  - On a step with pos<target: pos increments.
  - On a step with pos==target (commit): write turn into stored [col][target], toggle turn (01<->10), increment move_count, pulse move_done in the next cycle.
  - After commit, go to FULL if the new move_count==42, otherwise to IDLE.
  - Commit occurs exactly (target+1)*DROP_TICKS cycles after the acceptance edge. target=0 commits after DROP_TICKS cycles.
- play_req during DROP or FULL is ignored: no invalid_move and no queueing.
- FULL: draw=1, all requests ignored, exit only via rst_n or new_game. Win detection is a separate downstream block, outside this block's scope.
- The panel output is combinational from registers; the committed piece becomes visible in the stored panel on the commit edge.
- Simultaneous play_req and new_game: new_game wins and the request is dropped.

Decomposition:
- score4_pkg holds:
  - COLS=7, ROWS=6
  - cell_t enum {EMPTY=2'b00, P1=2'b01, P2=2'b10}
  - panel_t = logic [COLS-1:0][ROWS-1:0][1:0]
  - state enum {IDLE, DROP, FULL}
  - MAX_MOVES=42
- One sub-module: drop_tick_gen. It is the DROP_TICKS tick counter with a clear input and a one-cycle step output, instantiated once.

Test Plan:
- Reset then empty panel, DROP_TICKS=4, play=7'b0001000 + play_req, free=5/valid=1 -> busy for 24 cycles; overlay walks [3][0]..[3][5]; then panel[3][5]=01, turn=10, move_count=1, move_done pulse.
- Column 0 full (all 01), play=7'b0000001, valid=0 -> invalid_move pulse; panel, turn and move_count unchanged; state stays IDLE.
- play=7'b0000011 or 7'b0000000 with play_req, valid=1 -> invalid_move pulse, no state change.
- Accept column 1 (free=2); pulse play_req on column 4 during the drop -> ignored, no invalid_move. Commit writes [1][2] after 12 cycles.
- Assert new_game mid-drop, then separately rst_n=0 mid-drop -> next cycle: panel all 00, busy=0, turn=01, move_count=0, no move_done.
- Play 42 legal moves -> after the 42nd commit draw=1; a further play_req gives no response until new_game, which clears draw and move_count.
